// File: rtl/frame_stream_merger.sv
// Round-robin, frame-atomic merger of N_CHANNELS word streams into one registered output stream.
// Optional header channel tagging is enabled by defining FRAME_MERGER_CH_TAG_EN.
module frame_stream_merger #(
  parameter int N_CHANNELS        = 4,
  parameter int CH_WIDTH          = 2,
  parameter int DATA_WIDTH        = 64,
  parameter int MAX_FRAME_LENGTH  = 200,
  parameter int CHANNEL_ID_OFFSET = 0,
  parameter int TAG_LSB           = 48
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [N_CHANNELS-1:0]            iVALID,
  output logic [N_CHANNELS-1:0]            oREADY,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] DIN,
  input  logic [N_CHANNELS-1:0]            iLAST,
  input  logic                             iREADY,
  output logic                             oVALID,
  output logic                             oLAST,
  output logic [DATA_WIDTH-1:0]            DOUT,
  output logic [CH_WIDTH-1:0]              oCHANNEL,
  output logic [15:0]                      TRUNC_CNT
);

  localparam int CntW = $clog2(MAX_FRAME_LENGTH + 1);
  localparam logic [CntW-1:0] MaxLen = CntW'(MAX_FRAME_LENGTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  if (N_CHANNELS < 1 || N_CHANNELS > 16 || (1 << CH_WIDTH) < N_CHANNELS) begin : gen_bad_ch
    $error("frame_stream_merger: bad N_CHANNELS/CH_WIDTH");
  end
  if (MAX_FRAME_LENGTH < 2 || CHANNEL_ID_OFFSET < 0 || TAG_LSB + 8 > DATA_WIDTH) begin : gen_bad_cfg
    $error("frame_stream_merger: bad frame length or tag configuration");
  end

  logic [0:0]            stateQ, stateD;
  logic [CH_WIDTH-1:0]   grantQ, grantD;
  logic [CH_WIDTH-1:0]   lastGrantQ, lastGrantD;
  logic [CntW-1:0]       cntQ, cntD;
  logic [15:0]           truncQ, truncD;
  logic                  outValidQ, outValidD;
  logic                  outLastQ, outLastD;
  logic [DATA_WIDTH-1:0] outDataQ, outDataD;
  logic [CH_WIDTH-1:0]   outChanQ, outChanD;

  logic                  curValid, curLast;
  logic [DATA_WIDTH-1:0] curData, wordOut;
  logic                  locked, slotFree, accept, atMax, frameEnd;
  logic [CntW-1:0]       cntInc;
  logic                  reqFound;
  logic [CH_WIDTH-1:0]   reqIdx;

  // Select the granted channel's inputs.
  always_comb begin
    curValid = 1'b0;
    curLast  = 1'b0;
    curData  = '0;
    for (int j = 0; j < N_CHANNELS; j++) begin
      if (grantQ == CH_WIDTH'(j)) begin
        curValid = iVALID[j];
        curLast  = iLAST[j];
        curData  = DIN[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign locked   = (stateQ == LOCKED);
  assign slotFree = !outValidQ | iREADY;
  assign accept   = locked & curValid & slotFree;
  assign cntInc   = cntQ + CntW'(1);
  assign atMax    = (cntInc == MaxLen);
  assign frameEnd = accept & (curLast | atMax);

  always_comb begin
    oREADY = '0;
    for (int j = 0; j < N_CHANNELS; j++) begin
      oREADY[j] = locked && (grantQ == CH_WIDTH'(j)) && slotFree;
    end
  end

  // Round-robin scan: distance i from the previous grant, first requester wins.
  always_comb begin
    reqFound = 1'b0;
    reqIdx   = '0;
    for (int i = 1; i <= N_CHANNELS; i++) begin
      for (int j = 0; j < N_CHANNELS; j++) begin
        if (!reqFound && iVALID[j] && (j == (int'(lastGrantQ) + i) % N_CHANNELS)) begin
          reqFound = 1'b1;
          reqIdx   = CH_WIDTH'(j);
        end
      end
    end
  end

`ifdef FRAME_MERGER_CH_TAG_EN
  logic [7:0] tagVal;
  always_comb begin
    tagVal  = 8'(int'(grantQ) + CHANNEL_ID_OFFSET);
    wordOut = curData;
    if (cntQ == '0) wordOut[TAG_LSB +: 8] = tagVal;
  end
`else
  assign wordOut = curData;
`endif

  always_comb begin
    stateD     = stateQ;
    grantD     = grantQ;
    lastGrantD = lastGrantQ;
    cntD       = cntQ;
    truncD     = truncQ;
    outValidD  = outValidQ;
    outLastD   = outLastQ;
    outDataD   = outDataQ;
    outChanD   = outChanQ;

    case (stateQ)
      IDLE: begin
        if (reqFound) begin
          grantD = reqIdx;
          cntD   = '0;
          stateD = LOCKED;
        end
      end
      LOCKED: begin
        if (accept) cntD = cntInc;
        if (frameEnd) begin
          stateD     = IDLE;
          lastGrantD = grantQ;
        end
      end
      default: stateD = IDLE;
    endcase

    if (accept && atMax && !curLast && truncQ != 16'hFFFF) truncD = truncQ + 16'd1;

    if (accept) begin
      outValidD = 1'b1;
      outLastD  = curLast | atMax;
      outDataD  = wordOut;
      outChanD  = grantQ;
    end else if (iREADY) begin
      outValidD = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateQ     <= IDLE;
      grantQ     <= '0;
      lastGrantQ <= CH_WIDTH'(N_CHANNELS - 1);
      cntQ       <= '0;
      truncQ     <= '0;
      outValidQ  <= 1'b0;
      outLastQ   <= 1'b0;
      outDataQ   <= '0;
      outChanQ   <= '0;
    end else begin
      stateQ     <= stateD;
      grantQ     <= grantD;
      lastGrantQ <= lastGrantD;
      cntQ       <= cntD;
      truncQ     <= truncD;
      outValidQ  <= outValidD;
      outLastQ   <= outLastD;
      outDataQ   <= outDataD;
      outChanQ   <= outChanD;
    end
  end

  assign oVALID    = outValidQ;
  assign oLAST     = outLastQ;
  assign DOUT      = outDataQ;
  assign oCHANNEL  = outChanQ;
  assign TRUNC_CNT = truncQ;

endmodule

// File: tb/tb_frame_stream_merger.sv
// Randomized and directed bench for frame_stream_merger against a frame-level round-robin model.
module tb_frame_stream_merger;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int MAX = 200;
  localparam int OFS = 8;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } word_t;

  logic            CLK;
  logic            RESET;
  logic [N-1:0]    iVALID;
  logic [N-1:0]    oREADY;
  logic [N*DW-1:0] DIN;
  logic [N-1:0]    iLAST;
  logic            iREADY;
  logic            oVALID;
  logic            oLAST;
  logic [DW-1:0]   DOUT;
  logic [1:0]      oCHANNEL;
  logic [15:0]     TRUNC_CNT;

  frame_stream_merger #(
    .N_CHANNELS       (N),
    .CH_WIDTH         (2),
    .DATA_WIDTH       (DW),
    .MAX_FRAME_LENGTH (MAX),
    .CHANNEL_ID_OFFSET(OFS),
    .TAG_LSB          (48)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .DIN      (DIN),
    .iLAST    (iLAST),
    .iREADY   (iREADY),
    .oVALID   (oVALID),
    .oLAST    (oLAST),
    .DOUT     (DOUT),
    .oCHANNEL (oCHANNEL),
    .TRUNC_CNT(TRUNC_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int nChecks = 0;
  int nPass   = 0;

  word_t       srcQ [N][$];
  logic [63:0] expData [$];
  bit          expLast [$];
  int          expChan [$];
  int          expTrunc [$];
  logic [63:0] obsData [$];
  bit          obsLast [$];
  int          obsChan [$];
  int          obsCyc [$];
  int          outIdx;
  int          cyc;
  int          frmCnt [N];
  bit          inFrame [N];
  bit          heldPrev;
  logic [63:0] prevData;
  logic        prevLast;
  logic [1:0]  prevChan;
  bit          rdyRandom;
  bit          gapEn;
  int          stallLo;
  int          stallHi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] tagWord(input logic [63:0] w, input int ch);
`ifdef FRAME_MERGER_CH_TAG_EN
    w[55:48] = 8'(ch + OFS);
`endif
    return w;
  endfunction

  task automatic addFrame(input int ch, input int len, input logic [63:0] base, input bit withLast);
    for (int i = 0; i < len; i++) srcQ[ch].push_back('{d: base + 64'(i), l: withLast && (i == len - 1)});
  endtask

  // Frame-level reference: pick the next non-empty channel after the last one served, take
  // its whole frame (up to MAX words), repeat.  All sources are presented continuously.
  task automatic buildExpected();
    word_t q [N][$];
    int lastG = N - 1;
    int trunc = 0;
    for (int k = 0; k < N; k++) q[k] = srcQ[k];
    expData.delete(); expLast.delete(); expChan.delete(); expTrunc.delete();
    while (1) begin
      int g = -1;
      int n = 0;
      bit closed = 0;
      for (int i = 1; i <= N; i++)
        if (g < 0 && q[(lastG + i) % N].size() > 0) g = (lastG + i) % N;
      if (g < 0) break;
      while (q[g].size() > 0) begin
        word_t w = q[g].pop_front();
        n++;
        if (n == MAX && !w.l) trunc++;
        expData.push_back(n == 1 ? tagWord(w.d, g) : w.d);
        expLast.push_back(w.l || n == MAX);
        expChan.push_back(g);
        expTrunc.push_back(trunc);
        if (w.l || n == MAX) begin
          closed = 1;
          break;
        end
      end
      if (!closed) break;
      lastG = g;
    end
  endtask

  task automatic doReset();
    RESET  = 1'b1;
    iVALID = '0;
    iLAST  = '0;
    iREADY = 1'b0;
    #1;
    chk("rst_ovalid", 64'(oVALID), 64'd0);
    chk("rst_olast", 64'(oLAST), 64'd0);
    chk("rst_dout", DOUT, 64'd0);
    chk("rst_ochannel", 64'(oCHANNEL), 64'd0);
    chk("rst_oready", 64'(oREADY), 64'd0);
    chk("rst_trunc", 64'(TRUNC_CNT), 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int k = 0; k < N; k++) begin
      srcQ[k].delete();
      frmCnt[k]  = 0;
      inFrame[k] = 0;
    end
    obsData.delete(); obsLast.delete(); obsChan.delete(); obsCyc.delete();
    outIdx    = 0;
    heldPrev  = 0;
    rdyRandom = 0;
    gapEn     = 0;
    stallLo   = 0;
    stallHi   = 0;
  endtask

  task automatic runTraffic(input int target, input int budget);
    for (int c = 0; c < budget && outIdx < target; c++) begin
      iREADY = rdyRandom ? ($urandom_range(0, 99) < 70) : 1'b1;
      if (c >= stallLo && c < stallHi) iREADY = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (srcQ[k].size() > 0 && !(inFrame[k] && gapEn && $urandom_range(0, 99) < 20)) begin
          iVALID[k]         = 1'b1;
          DIN[k*DW +: DW]   = srcQ[k][0].d;
          iLAST[k]          = srcQ[k][0].l;
        end else begin
          iVALID[k]         = 1'b0;
          DIN[k*DW +: DW]   = {$urandom, $urandom};
          iLAST[k]          = 1'($urandom);
        end
      end
      #1;
      if (heldPrev) begin
        chk("stall_ovalid", 64'(oVALID), 64'd1);
        chk("stall_dout", DOUT, prevData);
        chk("stall_olast", 64'(oLAST), 64'(prevLast));
        chk("stall_ochannel", 64'(oCHANNEL), 64'(prevChan));
      end
      chk("oready_onehot0", 64'($countones(oREADY) <= 1), 64'd1);
      if (oVALID && !iREADY) chk("oready_backpressure", 64'(oREADY), 64'd0);
      if (oVALID) begin
        if (outIdx < expData.size()) chk("trunc_cnt", 64'(TRUNC_CNT), 64'(expTrunc[outIdx]));
        else chk("extra_word", 64'(outIdx), 64'(expData.size()));
      end
      if (oVALID && iREADY && outIdx < expData.size()) begin
        chk("dout", DOUT, expData[outIdx]);
        chk("olast", 64'(oLAST), 64'(expLast[outIdx]));
        chk("ochannel", 64'(oCHANNEL), 64'(expChan[outIdx]));
        obsData.push_back(DOUT);
        obsLast.push_back(oLAST);
        obsChan.push_back(int'(oCHANNEL));
        obsCyc.push_back(cyc);
        outIdx++;
      end
      heldPrev = oVALID && !iREADY;
      prevData = DOUT;
      prevLast = oLAST;
      prevChan = oCHANNEL;
      for (int k = 0; k < N; k++) begin
        if (iVALID[k] && oREADY[k] && srcQ[k].size() > 0) begin
          word_t w = srcQ[k].pop_front();
          frmCnt[k]++;
          if (w.l || frmCnt[k] == MAX) begin
            frmCnt[k]  = 0;
            inFrame[k] = 0;
          end else begin
            inFrame[k] = 1;
          end
        end
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("words_delivered", 64'(outIdx), 64'(target));
  endtask

  initial begin
    RESET  = 1'b1;
    iVALID = '0;
    iLAST  = '0;
    DIN    = '0;
    iREADY = 1'b0;
    cyc    = 0;
    #2;
    doReset();

    // Two 3-word frames on channels 0 and 2.
    addFrame(0, 3, 64'hA0, 1);
    addFrame(2, 3, 64'hC0, 1);
    buildExpected();
    runTraffic(6, 100);
    if (obsChan.size() == 6) begin
      chk("t1_chan0", 64'(obsChan[0]), 64'd0);
      chk("t1_chan2", 64'(obsChan[2]), 64'd0);
      chk("t1_chan3", 64'(obsChan[3]), 64'd2);
      chk("t1_chan5", 64'(obsChan[5]), 64'd2);
      chk("t1_last2", 64'(obsLast[2]), 64'd1);
      chk("t1_last1", 64'(obsLast[1]), 64'd0);
      chk("t1_last5", 64'(obsLast[5]), 64'd1);
      chk("t1_data1", obsData[1], 64'hA1);
      chk("t1_data4", obsData[4], 64'hC1);
      chk("t1_contig", 64'(obsCyc[2] - obsCyc[0]), 64'd2);
      chk("t1_bubble", 64'(obsCyc[3] - obsCyc[2]), 64'd2);
    end

    // All four channels stream 2-word frames.
    doReset();
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < N; k++) addFrame(k, 2, 64'(k * 256 + f * 16), 1);
    buildExpected();
    runTraffic(24, 300);
    if (obsChan.size() == 24)
      for (int i = 0; i < 12; i++) chk("t2_rr_order", 64'(obsChan[2 * i]), 64'(i % 4));

    // 205 words on channel 1 without iLAST: forced termination at word 200.
    doReset();
    addFrame(1, 205, 64'h1000, 0);
    buildExpected();
    runTraffic(205, 1000);
    chk("t3_trunc_total", 64'(TRUNC_CNT), 64'd1);
    if (obsLast.size() == 205) begin
      chk("t3_last199", 64'(obsLast[198]), 64'd0);
      chk("t3_last200", 64'(obsLast[199]), 64'd1);
      chk("t3_last205", 64'(obsLast[204]), 64'd0);
      chk("t3_rearb_gap", 64'(obsCyc[200] - obsCyc[199]), 64'd2);
      chk("t3_chan205", 64'(obsChan[204]), 64'd1);
      chk("t3_data200", obsData[200], 64'h1000 + 64'd200);
    end

    // iREADY low for 10 cycles mid-frame.
    doReset();
    addFrame(0, 8, 64'h100, 1);
    addFrame(2, 3, 64'h200, 1);
    stallLo = 5;
    stallHi = 15;
    buildExpected();
    runTraffic(11, 200);
    if (obsData.size() == 11) begin
      chk("t4_data7", obsData[7], 64'h107);
      chk("t4_chan8", 64'(obsChan[8]), 64'd2);
    end

    // Reset during word 2 of a 4-word frame on channel 1, after channel 0 was served.
    doReset();
    addFrame(0, 1, 64'h300, 1);
    addFrame(1, 4, 64'h310, 1);
    buildExpected();
    runTraffic(2, 100);
    doReset();
    addFrame(0, 1, 64'h400, 1);
    addFrame(1, 1, 64'h410, 1);
    buildExpected();
    runTraffic(2, 100);
    if (obsChan.size() == 2) begin
      chk("t5_first_ch0", 64'(obsChan[0]), 64'd0);
      chk("t5_second_ch1", 64'(obsChan[1]), 64'd1);
    end

    // Header tagging on channel 3.
    doReset();
    addFrame(3, 2, 64'hAA00_0000_0000_0001, 1);
    buildExpected();
    runTraffic(2, 100);
    if (obsData.size() == 2) begin
`ifdef FRAME_MERGER_CH_TAG_EN
      chk("t6_tagged_header", obsData[0], 64'hAA0B_0000_0000_0001);
`else
      chk("t6_plain_header", obsData[0], 64'hAA00_0000_0000_0001);
`endif
      chk("t6_second_word", obsData[1], 64'hAA00_0000_0000_0002);
    end

    // Randomized traffic with backpressure, valid gaps and a forced termination.
    for (int r = 0; r < 2; r++) begin
      doReset();
      rdyRandom = 1;
      gapEn     = 1;
      for (int k = 0; k < N; k++) begin
        int nf = $urandom_range(2, 5);
        for (int f = 0; f < nf; f++)
          addFrame(k, $urandom_range(1, 6), 64'({$urandom, $urandom}), 1);
      end
      addFrame(2, 203, 64'h5000, 1);
      buildExpected();
      runTraffic(expData.size(), 6000);
      chk("rand_trunc_total", 64'(TRUNC_CNT), 64'd1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
